// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register and its slots.
package if_id_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } if_id_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_slot.sv
// Load-enabled PC/instruction holding register with a parameterised
// asynchronous reset value.
module if_id_slot
    import if_id_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [31:0] RESET_INSTR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    output logic [31:0] pc_q,
    output logic [31:0] instr_q
);

    if_id_payload_t data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data.pc    <= RESET_PC;
            data.instr <= RESET_INSTR;
        end else if (load) begin
            data.pc    <= pc_d;
            data.instr <= instr_d;
        end
    end

    assign pc_q    = data.pc;
    assign instr_q = data.instr;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer (main + skid slot).
// Define IF_ID_STALL_CNT_EN to add the saturating stall_cnt output.
module if_id_skid
    import if_id_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instr_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      pc_out,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_plus4_out
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if_id_state_t state;
    if_id_state_t next_state;

    logic        in_xfer;
    logic        out_xfer;
    logic        load_main;
    logic        load_skid;
    logic        main_from_skid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic [31:0] main_pc_d;
    logic [31:0] main_instr_d;

    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    // Flush wins over everything and leaves the slots untouched, so the
    // outputs keep their last values while out_valid is low.
    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        next_state = ONE;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        next_state = FULL;
                        load_skid  = 1'b1;
                    end else if (out_xfer) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        next_state     = ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    assign main_pc_d    = main_from_skid ? skid_pc    : pc_in;
    assign main_instr_d = main_from_skid ? skid_instr : instr_in;

    if_id_slot #(
        .RESET_PC    (32'h0),
        .RESET_INSTR (NOP_INSTR)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (load_main),
        .pc_d    (main_pc_d),
        .instr_d (main_instr_d),
        .pc_q    (pc_out),
        .instr_q (instr_out)
    );

    if_id_slot #(
        .RESET_PC    (32'h0),
        .RESET_INSTR (32'h0)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (load_skid),
        .pc_d    (pc_in),
        .instr_d (instr_in),
        .pc_q    (skid_pc),
        .instr_q (skid_instr)
    );

    assign pc_plus4_out = pc_out + 32'd4;

`ifdef IF_ID_STALL_CNT_EN
    // Counts back-pressure cycles; only reset clears it, flush does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the optional stall counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pc_in  input  32  fetch-stage PC; connects to the output of pc.
REQ-005 SHALL have port instr_in  input  32  instruction fetched at pc_in.
REQ-006 SHALL have port in_valid  input  1  fetch offers pc_in/instr_in this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle; driven from a register.
REQ-008 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-009 SHALL have port out_valid  output  1  decode-side payload valid.
REQ-010 SHALL have port out_ready  input  1  decode consumes the payload this cycle.
REQ-011 SHALL have port pc_out  output  32  held PC.
REQ-012 SHALL have port instr_out  output  32  held instruction.
REQ-013 SHALL have port pc_plus4_out  output  32  pc_out+4.
REQ-014 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, present only under IF_ID_STALL_CNT_EN.

Function
REQ-015 SHALL hold the payload in a main slot and a skid slot, tracked by states EMPTY, ONE and FULL.
REQ-016 SHALL complete an input transfer on in_valid and in_ready, and an output transfer on out_valid and out_ready.
REQ-017 SHALL drive in_ready=1 in EMPTY and ONE, and in_ready=0 in FULL.
REQ-018 SHALL drive out_valid=1 in ONE and FULL, and out_valid=0 in EMPTY.
REQ-019 SHALL move from EMPTY to ONE on an input transfer, loading the main slot; it SHALL otherwise stay in EMPTY.
REQ-020 SHALL handle ONE as follows.
- Input and output transfer together: stay in ONE and replace the main slot.
- Input transfer only: go to FULL and capture the input in the skid slot.
- Output transfer only: go to EMPTY.
- Neither: hold.
REQ-021 SHALL, in FULL, move the skid slot into the main slot and go to ONE on an output transfer; it SHALL otherwise hold.
REQ-022 SHALL present a main-slot payload on the outputs on the clock edge after its input transfer, giving 1-cycle latency.
REQ-023 SHALL never drop, duplicate or reorder entries in the absence of flush.
REQ-024 SHALL compute pc_plus4_out as pc_out+4 modulo 2^32, so 32'hFFFF_FFFC yields 32'h0000_0000.
REQ-025 SHALL, on flush=1, go to EMPTY on the next edge, discarding both slots and any input offered in the same cycle.
REQ-026 SHALL give flush priority over every simultaneous transfer.
REQ-027 SHALL hold pc_out, instr_out and pc_plus4_out at their last values while out_valid=0.

Reset
REQ-028 SHALL, on reset assertion, immediately and asynchronously set the following.
- State: EMPTY.
- out_valid: 0.
- in_ready: 1.
- pc_out: 32'h0.
- pc_plus4_out: 32'h4.
- instr_out: NOP 32'h0000_0013.
- Skid slot: zero.
- stall_cnt: 0.
REQ-029 SHALL abandon any in-progress transfer when reset asserts mid-operation, with no entry surviving.

Configuration
REQ-030 SHALL, with IF_ID_STALL_CNT_EN defined, include stall_cnt.
- It increments each cycle with out_valid=1 and out_ready=0.
- It saturates at all-ones.
- It is cleared by reset only; flush does not clear it.
REQ-031 SHALL, without IF_ID_STALL_CNT_EN, omit the stall_cnt port and its logic, with all other behaviour identical.

Structure
REQ-032 SHALL take the following from the shared package if_id_pkg.
- Payload typedef if_id_payload_t holding pc and instr, each 32 bits.
- State enum if_id_state_t with values EMPTY, ONE and FULL.
- Constant NOP_INSTR = 32'h0000_0013.
REQ-033 SHALL implement each slot as an instance of sub-module if_id_slot, a load-enabled payload register with asynchronous reset to the value given by a parameter.

Verification
REQ-034 SHALL verify: after reset, drive in_valid=1 with pc_in=32'hAABBCCDD and instr_in=32'h00500093 -> the next edge gives out_valid=1, pc_out=AABBCCDD and pc_plus4_out=AABBCCE1.
REQ-035 SHALL verify: with out_ready=0, send two entries with pc 32'h100 then 32'h104 -> state FULL and in_ready=0; then assert out_ready for two cycles -> the bench observes 100 then 104, in order.
REQ-036 SHALL verify: with state FULL, assert flush together with in_valid for pc 32'h200 -> the next edge gives out_valid=0 and in_ready=1, and pc 200 never appears.
REQ-037 SHALL verify: load pc_in=32'hFFFFFFFC -> pc_plus4_out=32'h00000000.
REQ-038 SHALL verify: assert reset asynchronously mid-cycle while FULL -> the outputs immediately show the reset values, before the next clock edge.
REQ-039 SHALL verify, with IF_ID_STALL_CNT_EN and CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 4'hF.
